uart_rx_ctrl: RTL and testbench

- Receive-side sequencer for the UART RX path. It detects the start bit, runs the oversampling edge counter and bit counter, and drives the sampler and deserializer enables.
- Tracks data parity, then checks the parity and stop bits.
- Emits a one-cycle data-valid pulse plus error flags toward the processing-unit receive interface.
- Sits between the synchronized serial line and the sampler/deserializer pair.

---
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, oversampling edge/bit counters,
// sampler/deserializer enables, parity and stop checking, valid/error reporting.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EDGE_W     = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_in,
  input  logic              i_sampled_bit,
  input  logic              i_par_en,
  input  logic              i_par_typ,
  output logic [EDGE_W-1:0] o_edge_cnt,
  output logic [3:0]        o_bit_cnt,
  output logic              o_en_sample,
  output logic              o_en_deser,
  output logic              o_data_valid,
  output logic              o_par_err,
  output logic              o_stop_err,
  output logic              o_busy
);

  localparam logic [EDGE_W-1:0] EdgeLast = '1;
  localparam logic [3:0]        BitLast  = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [3:0]        bit_q, bit_d;
  logic              acc_q, acc_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_err_q, par_err_d;
  logic              stop_err_q, stop_err_d;
  logic              valid_q, valid_d;

  logic last_edge;
  logic start_frame;

  assign last_edge   = (edge_q == EdgeLast);
  assign start_frame = (state_q == StIdle) && !i_rx_in;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every decision after IDLE is taken on the last oversampling edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!i_rx_in) state_d = StStart;
      // A 1 at the middle of the start bit means the low pulse was a glitch.
      StStart:  if (last_edge) state_d = i_sampled_bit ? StIdle : StData;
      StData:   if (last_edge && (bit_q == BitLast)) state_d = par_en_q ? StParity : StStop;
      StParity: if (last_edge) state_d = StStop;
      StStop:   if (last_edge) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counters, parity accumulator, latched config and error/valid flags.
  always_comb begin
    edge_d     = (state_q == StIdle) ? '0 : EDGE_W'(edge_q + 1'b1);
    bit_d      = bit_q;
    acc_d      = acc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    valid_d    = 1'b0;

    if (start_frame) begin
      acc_d      = 1'b0;
      par_en_d   = i_par_en;
      par_typ_d  = i_par_typ;
      par_err_d  = 1'b0;
      stop_err_d = 1'b0;
    end

    if (last_edge) begin
      unique case (state_q)
        StStart: bit_d = '0;
        StData: begin
          acc_d = acc_q ^ i_sampled_bit;
          bit_d = (bit_q == BitLast) ? 4'd0 : bit_q + 4'd1;
        end
        // Odd parity expects the complement of the running XOR.
        StParity: par_err_d = (i_sampled_bit != (acc_q ^ par_typ_q));
        StStop: begin
          stop_err_d = ~i_sampled_bit;
          valid_d    = i_sampled_bit && !par_err_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      edge_q     <= '0;
      bit_q      <= '0;
      acc_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      acc_q      <= acc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      valid_q    <= valid_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    o_en_sample = (state_q != StIdle);
    o_busy      = (state_q != StIdle);
    o_en_deser  = (state_q == StData);
  end

  assign o_edge_cnt   = edge_q;
  assign o_bit_cnt    = bit_q;
  assign o_data_valid = valid_q;
  assign o_par_err    = par_err_q;
  assign o_stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural LSB-first deserializer.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       sampled = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       en_sample, en_deser, data_valid, par_err, stop_err, busy;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int deser_cyc = 0;
  int p0, d0;
  logic [7:0] deser = 8'h00;

  uart_rx_ctrl #(.DATA_WIDTH(8), .EDGE_W(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_in      (rx_in),
    .i_sampled_bit(sampled),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_edge_cnt   (edge_cnt),
    .o_bit_cnt    (bit_cnt),
    .o_en_sample  (en_sample),
    .o_en_deser   (en_deser),
    .o_data_valid (data_valid),
    .o_par_err    (par_err),
    .o_stop_err   (stop_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Deserializer model and activity counters.
  always @(posedge clk) begin
    if (en_deser && edge_cnt == 3'd7) deser <= {sampled, deser[7:1]};
    if (data_valid) pulses <= pulses + 1;
    if (en_deser) deser_cyc <= deser_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx_in = b;
    sampled = b;
    repeat (8) @(posedge clk);
  endtask

  // Returns on the posedge holding the stop-bit last edge.
  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                            input logic sbit);
    rx_in = 1'b0;
    sampled = 1'b0;
    @(posedge clk);
    #1;
    chk("start_edge0", {29'd0, edge_cnt}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_clr_par", {31'd0, par_err}, 32'd0);
    chk("start_clr_stop", {31'd0, stop_err}, 32'd0);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(pbit);
    drive_bit(sbit);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_edge", {29'd0, edge_cnt}, 32'd0);
    chk("rst_bit", {28'd0, bit_cnt}, 32'd0);
    chk("rst_outs", {26'd0, en_sample, en_deser, data_valid, par_err, stop_err, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outs", {26'd0, en_sample, en_deser, data_valid, par_err, stop_err, busy}, 32'd0);

    // 1: 0xA5, no parity
    d0 = deser_cyc; p0 = pulses;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_valid", {31'd0, data_valid}, 32'd1);
    chk("t1_data", {24'd0, deser}, 32'hA5);
    chk("t1_errs", {30'd0, par_err, stop_err}, 32'd0);
    chk("t1_bitcnt", {28'd0, bit_cnt}, 32'd0);
    chk("t1_idle", {30'd0, busy, en_sample}, 32'd0);
    @(negedge clk);
    chk("t1_pulse_end", {31'd0, data_valid}, 32'd0);
    chk("t1_deser_cyc", deser_cyc - d0, 32'd64);
    chk("t1_pulses", pulses - p0, 32'd1);

    // 2: 0xA5 even parity, good then bad parity bit
    par_en = 1'b1; par_typ = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2a_valid", {31'd0, data_valid}, 32'd1);
    chk("t2a_par_err", {31'd0, par_err}, 32'd0);
    chk("t2a_data", {24'd0, deser}, 32'hA5);
    repeat (2) @(negedge clk);
    p0 = pulses;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2b_valid", {31'd0, data_valid}, 32'd0);
    chk("t2b_par_err", {31'd0, par_err}, 32'd1);
    chk("t2b_stop_err", {31'd0, stop_err}, 32'd0);
    @(negedge clk);
    chk("t2b_pulses", pulses - p0, 32'd0);
    chk("t2b_par_hold", {31'd0, par_err}, 32'd1);

    // 3: 0x3C odd parity bit 1, stop bit 0; then a good frame clears the flag
    par_typ = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pulses;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rx_in = 1'b1; sampled = 1'b1;
    chk("t3_stop_err", {31'd0, stop_err}, 32'd1);
    chk("t3_par_err", {31'd0, par_err}, 32'd0);
    chk("t3_valid", {31'd0, data_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_stop_hold", {31'd0, stop_err}, 32'd1);
    chk("t3_pulses", pulses - p0, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t3b_valid", {31'd0, data_valid}, 32'd1);
    chk("t3b_errs", {30'd0, par_err, stop_err}, 32'd0);
    chk("t3b_data", {24'd0, deser}, 32'h3C);

    // 4: glitch on the start bit
    par_en = 1'b0; par_typ = 1'b0;
    repeat (2) @(negedge clk);
    d0 = deser_cyc; p0 = pulses;
    rx_in = 1'b0; sampled = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx_in = 1'b1; sampled = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_flags", {29'd0, data_valid, par_err, stop_err}, 32'd0);
    chk("t4_deser_cyc", deser_cyc - d0, 32'd0);
    chk("t4_pulses", pulses - p0, 32'd0);

    // 5: back-to-back 0x3C, 0xC3 without an idle gap
    repeat (2) @(negedge clk);
    p0 = pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5a_valid", {31'd0, data_valid}, 32'd1);
    chk("t5a_data", {24'd0, deser}, 32'h3C);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5b_valid", {31'd0, data_valid}, 32'd1);
    chk("t5b_data", {24'd0, deser}, 32'hC3);
    @(negedge clk);
    chk("t5_pulses", pulses - p0, 32'd2);

    // 6: asynchronous reset during data bit 4, then 0x55
    repeat (2) @(negedge clk);
    rx_in = 1'b0; sampled = 1'b0;
    repeat (9) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h55 >> i) & 8'h01));
    @(negedge clk);
    rx_in = 1'b1; sampled = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_deser", {31'd0, en_deser}, 32'd1);
    chk("t6_pre_bit", {28'd0, bit_cnt}, 32'd4);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_edge", {29'd0, edge_cnt}, 32'd0);
    chk("t6_rst_bit", {28'd0, bit_cnt}, 32'd0);
    chk("t6_rst_outs", {26'd0, en_sample, en_deser, data_valid, par_err, stop_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    p0 = pulses;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_valid", {31'd0, data_valid}, 32'd1);
    chk("t6_data", {24'd0, deser}, 32'h55);
    @(negedge clk);
    chk("t6_pulses", pulses - p0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
